// File: rtl/swap_ctrl.sv
// rtl/swap_ctrl.sv - swap sequencer and host port mux for a 1R/1W register file
//
// Executes a swap of two register-file words as read A, read B, write A,
// write B on the file's plain ports. While idle, the host port is passed
// straight through to the file.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               swap request (accepted in IDLE, and in DONE for back-to-back)
//   address_A/B         swap addresses, captured with start
//   busy, done          swap in progress / one-cycle completion pulse
//   host_we, host_address_w, host_data_w, host_address_r, host_data_r
//                       host access port, passed through when idle
//   host_err            host write attempted while busy (write dropped)
//   swap_cnt            saturating count of completed swaps
//   rf_we, rf_address_w, rf_data_w, rf_address_r, rf_data_r
//                       register file ports (combinational read, sync write)
module swap_ctrl #(
  parameter int mem_width  = 7,
  parameter int data_width = 8,
  parameter int cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [mem_width-1:0]  address_A,
  input  logic [mem_width-1:0]  address_B,
  output logic                  busy,
  output logic                  done,
  input  logic                  host_we,
  input  logic [mem_width-1:0]  host_address_w,
  input  logic [data_width-1:0] host_data_w,
  input  logic [mem_width-1:0]  host_address_r,
  output logic [data_width-1:0] host_data_r,
  output logic                  host_err,
  output logic [cnt_width-1:0]  swap_cnt,
  output logic                  rf_we,
  output logic [mem_width-1:0]  rf_address_w,
  output logic [data_width-1:0] rf_data_w,
  output logic [mem_width-1:0]  rf_address_r,
  input  logic [data_width-1:0] rf_data_r
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR_A = 3'd3,
    WR_B = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t                state_q;
  logic [mem_width-1:0]  addr_a_q;
  logic [mem_width-1:0]  addr_b_q;
  logic [data_width-1:0] tmp_a_q;
  // Holds the word read from B (written to A), then tmp_a (written to B).
  logic [data_width-1:0] wdata_q;
  logic [mem_width-1:0]  waddr_q;
  logic [mem_width-1:0]  raddr_q;
  logic                  we_q;
  logic                  done_q;
  logic [cnt_width-1:0]  cnt_q;

  logic idle;
  logic accept;

  assign idle   = (state_q == IDLE);
  // DONE also accepts start so back-to-back swaps run every five cycles.
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tmp_a_q  <= '0;
      wdata_q  <= '0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: ;
        RD_A: begin
          tmp_a_q <= rf_data_r;
          raddr_q <= addr_b_q;
          state_q <= RD_B;
        end
        RD_B: begin
          wdata_q <= rf_data_r;
          waddr_q <= addr_a_q;
          we_q    <= 1'b1;
          state_q <= WR_A;
        end
        WR_A: begin
          wdata_q <= tmp_a_q;
          waddr_q <= addr_b_q;
          state_q <= WR_B;
        end
        WR_B: begin
          we_q    <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (cnt_q != {cnt_width{1'b1}}) begin
            cnt_q <= cnt_q + cnt_width'(1);
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Overrides the DONE->IDLE transition when a new request is taken.
      if (accept) begin
        addr_a_q <= address_A;
        addr_b_q <= address_B;
        if (address_A != address_B) begin
          raddr_q <= address_A;
          state_q <= RD_A;
        end else begin
          // Identical addresses: nothing to move, report completion at once.
          done_q  <= 1'b1;
          state_q <= DONE;
        end
      end
    end
  end

  assign busy     = !idle;
  assign done     = done_q;
  assign host_err = !idle && host_we;
  assign swap_cnt = cnt_q;

  // reset_n gates rf_we so the file sees no write while reset is held,
  // even if the host is driving host_we.
  assign rf_we        = reset_n && (idle ? host_we : we_q);
  assign rf_address_w = idle ? host_address_w : waddr_q;
  assign rf_data_w    = idle ? host_data_w    : wdata_q;
  assign rf_address_r = idle ? host_address_r : raddr_q;
  assign host_data_r  = rf_data_r;

endmodule

// File: tb/tb_swap_ctrl.sv
// tb/tb_swap_ctrl.sv - directed self-checking bench for swap_ctrl
module tb_swap_ctrl;
  localparam int MW = 7;
  localparam int DW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [MW-1:0] address_A = '0;
  logic [MW-1:0] address_B = '0;
  logic          busy;
  logic          done;
  logic          host_we = 1'b0;
  logic [MW-1:0] host_address_w = '0;
  logic [DW-1:0] host_data_w = '0;
  logic [MW-1:0] host_address_r = '0;
  logic [DW-1:0] host_data_r;
  logic          host_err;
  logic [CW-1:0] swap_cnt;
  logic          rf_we;
  logic [MW-1:0] rf_address_w;
  logic [DW-1:0] rf_data_w;
  logic [MW-1:0] rf_address_r;
  logic [DW-1:0] rf_data_r;

  logic [DW-1:0] mem [0:(1<<MW)-1];
  logic          clr = 1'b1;
  int            we_cnt = 0;
  int            n_checks = 0;
  int            n_errors = 0;

  swap_ctrl #(.mem_width(MW), .data_width(DW), .cnt_width(CW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .address_A(address_A), .address_B(address_B),
    .busy(busy), .done(done),
    .host_we(host_we), .host_address_w(host_address_w), .host_data_w(host_data_w),
    .host_address_r(host_address_r), .host_data_r(host_data_r), .host_err(host_err),
    .swap_cnt(swap_cnt),
    .rf_we(rf_we), .rf_address_w(rf_address_w), .rf_data_w(rf_data_w),
    .rf_address_r(rf_address_r), .rf_data_r(rf_data_r)
  );

  always #5 clk = ~clk;

  // Register file: combinational read, synchronous write.
  assign rf_data_r = mem[rf_address_r];
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < (1 << MW); i++) mem[i] <= '0;
    end else if (rf_we) begin
      mem[rf_address_w] <= rf_data_w;
    end
  end

  always @(posedge clk) if (rf_we) we_cnt <= we_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [MW-1:0] a, input logic [DW-1:0] d);
    host_we = 1'b1;
    host_address_w = a;
    host_data_w = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic check_mem(input string tag, input logic [MW-1:0] a, input logic [DW-1:0] exp);
    host_address_r = a;
    #1;
    check(tag, host_data_r, exp);
  endtask

  // Issues one start pulse and follows the swap until busy drops.
  task automatic run_swap(input string tag, input logic [MW-1:0] a, input logic [MW-1:0] b,
                          input int exp_done_cyc, input int exp_busy);
    int dcyc;
    int bcnt;
    int dn;
    dcyc = -1;
    bcnt = 0;
    dn = 0;
    address_A = a;
    address_B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        dn++;
        if (dcyc < 0) dcyc = c;
      end
      if (!busy) break;
      bcnt++;
      tick();
    end
    check({tag, "_done_cyc"}, dcyc, exp_done_cyc);
    check({tag, "_busy_cyc"}, bcnt, exp_busy);
    check({tag, "_done_cnt"}, dn, 1);
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (busy && c < 20) begin
      tick();
      c++;
    end
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int w0;
    int dones [$];

    // Reset with host_we high: file must see no write.
    host_we = 1'b1;
    host_address_w = 7'd50;
    host_data_w = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", host_err, 1'b0);
    check("rst_cnt", swap_cnt, 2'd0);
    check("rst_we", rf_we, 1'b0);
    host_we = 1'b0;
    clr = 1'b0;
    reset_n = 1'b1;
    tick();
    check_mem("rst_mem50", 7'd50, 8'h00);

    // Fill 20..29 with their own index.
    for (int i = 20; i < 30; i++) host_write(7'(i), 8'(i));
    tick();

    // Plain swap 22/28.
    run_swap("swap1", 7'd22, 7'd28, 4, 5);
    for (int i = 20; i < 30; i++) begin
      check_mem($sformatf("swap1_mem%0d", i), 7'(i),
                (i == 22) ? 8'd28 : (i == 28) ? 8'd22 : 8'(i));
    end
    check("swap1_cnt", swap_cnt, 2'd1);

    // Identical addresses: immediate done, no file write.
    w0 = we_cnt;
    run_swap("same", 7'd25, 7'd25, 0, 1);
    check("same_we", we_cnt - w0, 0);
    check_mem("same_mem25", 7'd25, 8'd25);
    check("same_cnt", swap_cnt, 2'd2);

    // Host write and second start during a swap.
    address_A = 7'd20;
    address_B = 7'd21;
    start = 1'b1;
    tick();
    host_we = 1'b1;
    host_address_w = 7'd40;
    host_data_w = 8'hAA;
    address_A = 7'd5;
    address_B = 7'd6;
    #1;
    check("mid_err", host_err, 1'b1);
    check("mid_we", rf_we, 1'b0);
    #4;
    tick();
    host_we = 1'b0;
    start = 1'b0;
    #1;
    check("mid_err_clr", host_err, 1'b0);
    wait_idle("mid");
    check_mem("mid_mem40", 7'd40, 8'h00);
    check_mem("mid_mem20", 7'd20, 8'd21);
    check_mem("mid_mem21", 7'd21, 8'd20);
    check_mem("mid_mem5", 7'd5, 8'h00);
    check("mid_cnt", swap_cnt, 2'd3);

    // Host write and start in the same idle cycle.
    host_we = 1'b1;
    host_address_w = 7'd22;
    host_data_w = 8'h55;
    address_A = 7'd22;
    address_B = 7'd23;
    start = 1'b1;
    tick();
    host_we = 1'b0;
    start = 1'b0;
    wait_idle("coin");
    check_mem("coin_mem22", 7'd22, 8'd23);
    check_mem("coin_mem23", 7'd23, 8'h55);
    check("coin_cnt_sat", swap_cnt, 2'd3);

    // Reset during WR_B of swap 24/26.
    address_A = 7'd24;
    address_B = 7'd26;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("abort_wrb_we", rf_we, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_we", rf_we, 1'b0);
    check("abort_cnt", swap_cnt, 2'd0);
    check("abort_done", done, 1'b0);
    #1;
    reset_n = 1'b1;
    tick();
    check("abort_idle", busy, 1'b0);
    check_mem("abort_mem24", 7'd24, 8'd26);
    check_mem("abort_mem26", 7'd26, 8'd26);
    run_swap("post", 7'd24, 7'd27, 4, 5);
    check_mem("post_mem24", 7'd24, 8'd27);
    check_mem("post_mem27", 7'd27, 8'd26);
    check("post_cnt", swap_cnt, 2'd1);

    // Back-to-back swaps with start held high.
    address_A = 7'd20;
    address_B = 7'd21;
    start = 1'b1;
    tick();
    for (int c = 0; c < 20; c++) begin
      if (done) dones.push_back(c);
      if (c == 19) start = 1'b0;
      tick();
    end
    check("b2b_dones", dones.size(), 4);
    for (int i = 0; i < dones.size(); i++) begin
      check($sformatf("b2b_done%0d", i), dones[i], 4 + 5 * i);
    end
    wait_idle("b2b");
    check("b2b_cnt_sat", swap_cnt, 2'd3);
    check_mem("b2b_mem20", 7'd20, 8'd21);
    check_mem("b2b_mem21", 7'd21, 8'd20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
